edge_rate_counter: RTL

EDGE_RATE_COUNTER -- requirements
Module: edge_rate_counter

---
 rtl/edge_rate_counter_pkg.sv | 45 ++++
 rtl/edge_rate_channel.sv | 72 +++++++
 rtl/edge_rate_counter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/edge_rate_counter_pkg.sv
// Shared definitions for the edge rate counter: CSR map, CTRL/STATUS bit
// positions, edge-mode encodings and the window FSM states.
package edge_rate_counter_pkg;

    localparam logic [3:0] ADDR_CTRL        = 4'd0;
    localparam logic [3:0] ADDR_GATE        = 4'd1;
    localparam logic [3:0] ADDR_STATUS      = 4'd2;
    localparam logic [3:0] ADDR_WINCNT      = 4'd3;
    localparam logic [3:0] ADDR_RESULT_BASE = 4'd8;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_MODE_LSB  = 2;
    localparam int CTRL_START_BIT = 4;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_OVF_LSB  = 8;

    typedef enum logic [1:0] {
        MODE_RISE     = 2'd0,
        MODE_FALL     = 2'd1,
        MODE_BOTH     = 2'd2,
        MODE_RISE_ALT = 2'd3
    } edge_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Selects which detected transitions count under the given mode.
    function automatic logic qualify_edge(input edge_mode_t mode,
                                          input logic       rise,
                                          input logic       fall);
        logic q;
        case (mode)
            MODE_FALL: q = fall;
            MODE_BOTH: q = rise | fall;
            default:   q = rise;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_rate_channel.sv
// One measured channel: input synchronizer, edge detector, saturating edge
// counter, per-window result latch and sticky overflow flag.
module edge_rate_channel
    import edge_rate_counter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_async,
    input  edge_mode_t       edge_mode,
    input  logic             count_en,
    input  logic             window_end,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   edge_prev_p1;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   qual;
    logic                   at_max;
    logic [CNT_W-1:0]       cnt;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign sync_out = sync_p0[SYNC_STAGES-1];
    assign rise     = sync_out & ~edge_prev_p1;
    assign fall     = ~sync_out & edge_prev_p1;
    assign qual     = qualify_edge(edge_mode, rise, fall);
    assign at_max   = (cnt == {CNT_W{1'b1}});

    // Metastability synchronizer chain for the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_p0 <= '0;
        else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_async};
    end

    // Previous synchronized level, used to spot transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) edge_prev_p1 <= 1'b0;
        else       edge_prev_p1 <= sync_out;
    end

    // Edge counter: counts while measuring, clears at window end or when idle/aborted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        cnt <= '0;
        else if (window_end || !count_en) cnt <= '0;
        else if (qual)                    cnt <= sat_inc(cnt);
    end

    // Result latch includes the edge qualified on the window-end cycle itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           result <= '0;
        else if (window_end) result <= qual ? sat_inc(cnt) : cnt;
    end

    // Sticky overflow: an edge arriving at full scale sets it; set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          ovf <= 1'b0;
        else if (count_en && qual && at_max) ovf <= 1'b1;
        else if (ovf_clr)                   ovf <= 1'b0;
    end

endmodule

// File: rtl/edge_rate_counter.sv
// Multi-channel edge rate counter: counts input edges over a programmable
// gate window and publishes per-channel results through a small CSR block.
module edge_rate_counter
    import edge_rate_counter_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] GATE_RST    = 32'd50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic [3:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              csr_waitrequest,
    output logic              window_done
);

    state_t           state;
    state_t           next_state;
    logic             ctrl_en;
    logic             ctrl_cont;
    edge_mode_t       ctrl_mode;
    logic [31:0]      gate_reg;
    logic [31:0]      gate_cnt;
    logic [31:0]      gate_eff;
    logic             done_flag;
    logic [31:0]      wincnt;
    logic             ctrl_wr;
    logic             gate_wr;
    logic             stat_wr;
    logic             start_req;
    logic             disable_req;
    logic             window_end;
    logic             abort;
    logic             count_en;
    logic [CNT_W-1:0] result_pad [8];
    logic [7:0]       ovf_pad;
    logic [31:0]      rd_mux;

    assign csr_waitrequest = 1'b0;

    assign ctrl_wr     = csr_write && (csr_address == ADDR_CTRL);
    assign gate_wr     = csr_write && (csr_address == ADDR_GATE);
    assign stat_wr     = csr_write && (csr_address == ADDR_STATUS);
    assign start_req   = ctrl_wr && csr_writedata[CTRL_START_BIT] && csr_writedata[CTRL_EN_BIT];
    assign disable_req = ctrl_wr && !csr_writedata[CTRL_EN_BIT];
    assign gate_eff    = (gate_reg == 32'd0) ? 32'd1 : gate_reg;
    assign count_en    = (state == ST_RUN) && !abort;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next state plus window-end / abort decode; disable takes priority over window end.
    always_comb begin
        next_state = state;
        window_end = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (disable_req) begin
                    abort      = 1'b1;
                    next_state = ST_IDLE;
                end else if (gate_cnt == 32'd1) begin
                    window_end = 1'b1;
                    if (!ctrl_cont) next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Gate counter: loaded on entry, reloaded at window end so windows abut.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 gate_cnt <= 32'd0;
        else if (state == ST_IDLE && start_req)    gate_cnt <= gate_eff;
        else if (state == ST_RUN && window_end)    gate_cnt <= gate_eff;
        else if (state == ST_RUN)                  gate_cnt <= gate_cnt - 32'd1;
    end

    // CTRL and GATE registers; start is an action bit and is never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_cont <= 1'b0;
            ctrl_mode <= MODE_RISE;
            gate_reg  <= GATE_RST;
        end else begin
            if (ctrl_wr) begin
                ctrl_en   <= csr_writedata[CTRL_EN_BIT];
                ctrl_cont <= csr_writedata[CTRL_CONT_BIT];
                ctrl_mode <= edge_mode_t'(csr_writedata[CTRL_MODE_LSB +: 2]);
            end
            if (gate_wr) gate_reg <= csr_writedata;
        end
    end

    // Window bookkeeping: sticky done (set beats clear), window count, completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_flag   <= 1'b0;
            wincnt      <= 32'd0;
            window_done <= 1'b0;
        end else begin
            window_done <= window_end;
            if (window_end) begin
                done_flag <= 1'b1;
                wincnt    <= wincnt + 32'd1;
            end else if (stat_wr && csr_writedata[STAT_DONE_BIT]) begin
                done_flag <= 1'b0;
            end
        end
    end

    for (genvar n = 0; n < 8; n++) begin : g_ch
        if (n < NUM_CH) begin : g_inst
            edge_rate_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .sig_async  (sig_in[n]),
                .edge_mode  (ctrl_mode),
                .count_en   (count_en),
                .window_end (window_end),
                .ovf_clr    (stat_wr && csr_writedata[STAT_OVF_LSB + n]),
                .result     (result_pad[n]),
                .ovf        (ovf_pad[n])
            );
        end else begin : g_none
            assign result_pad[n] = '0;
            assign ovf_pad[n]    = 1'b0;
        end
    end

    // Read mux; unmapped addresses and absent channels read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (csr_address)
            ADDR_CTRL:   rd_mux = 32'({ctrl_mode, ctrl_cont, ctrl_en});
            ADDR_GATE:   rd_mux = gate_reg;
            ADDR_STATUS: rd_mux = {16'd0, ovf_pad, 6'd0, done_flag, (state == ST_RUN)};
            ADDR_WINCNT: rd_mux = wincnt;
            default: begin
                if ((csr_address & 4'b1000) == ADDR_RESULT_BASE)
                    rd_mux = 32'(result_pad[csr_address[2:0]]);
            end
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         csr_readdata <= 32'd0;
        else if (csr_read) csr_readdata <= rd_mux;
    end

endmodule
